// File: rtl/io_mapped_regfile.sv
// -----------------------------------------------------------------------------
// io_mapped_regfile
//
// Purpose:
//   2-read / 1-write CPU register file with a handful of memory-mapped I/O
//   slots. It sits between the processor datapath (decode reads, writeback
//   writes) and the board I/O (ADC header, servo PWM, switches, seven-seg).
//
//   Address map:
//     0  hardwired zero (reads 0, writes ignored)
//     1  ADC sample, zero-extended (read-only)
//     2  PWM configuration (read/write, low PWM_W bits exported on pwm_cfg)
//     5  synchronised rest_in in bit 0 (read-only)
//     6  synchronised active_in in bit 0 (read-only)
//     8  sticky ADC-ready flag in bit 0; any write clears it
//     *  every other address is a plain read/write register
//
//   Optional build macro:
//     WRITE_BYPASS_EN - when defined, a read port addressing the register being
//     written this cycle returns data_writeReg (write-first forwarding). Only
//     plain read/write addresses forward; 0, 1, 5, 6 and 8 never do. When it is
//     undefined, reads return the stored value and a write shows up the cycle
//     after its edge.
//
// Ports:
//   clock             in   1       system clock, all state on the rising edge
//   ctrl_reset_n      in   1       asynchronous active-low reset
//   ctrl_writeEnable  in   1       write strobe
//   ctrl_writeReg     in   ADDR_W  write address
//   data_writeReg     in   DATA_W  write data
//   ctrl_readRegA     in   ADDR_W  read address, port A
//   ctrl_readRegB     in   ADDR_W  read address, port B
//   data_readRegA     out  DATA_W  read data A (combinational)
//   data_readRegB     out  DATA_W  read data B (combinational)
//   adc_in            in   ADC_W   ADC parallel data, stable across the tick
//   rest_in           in   1       asynchronous discrete input
//   active_in         in   1       asynchronous discrete input
//   pwm_cfg           out  PWM_W   register 2 [PWM_W-1:0]
//   adc_ready_pulse   out  1       one-cycle pulse, coincident with ADC update
//   testing           out  DBG_W   register DBG_REG [DBG_LSB+DBG_W-1:DBG_LSB]
//
// Interface timing (single comment for the whole port set): there is no
// valid/ready handshake. A write is committed on the rising edge where
// ctrl_writeEnable is 1, and read ports are pure combinational muxes. The ADC
// sample is taken once every SAMPLE_DIV edges. adc_ready_pulse is high for
// exactly the one cycle that follows the edge that loads the new sample.
// -----------------------------------------------------------------------------
module io_mapped_regfile #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int ADC_W      = 8,
  parameter int SAMPLE_DIV = 500,
  parameter int PWM_W      = 3,
  parameter int DBG_REG    = 12,
  parameter int DBG_LSB    = 3,
  parameter int DBG_W      = 16
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic [ADC_W-1:0]  adc_in,
  input  logic              rest_in,
  input  logic              active_in,
  output logic [PWM_W-1:0]  pwm_cfg,
  output logic              adc_ready_pulse,
  output logic [DBG_W-1:0]  testing
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [ADDR_W-1:0] A_ZERO   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_ADC    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PWM    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_REST   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_ACTIVE = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_FLAG   = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_DBG    = ADDR_W'(DBG_REG);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SAMPLE_DIV - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // The entries at the special addresses exist in the array but are never
  // written. Their reads are overridden in the read mux below.
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic [ADC_W-1:0] adc_q,        adc_d;
  logic [CNT_W-1:0] div_cnt_q,    div_cnt_d;
  logic             flag_q,       flag_d;
  logic             pulse_q,      pulse_d;
  logic             rest_s1_q,    rest_s2_q;
  logic             active_s1_q,  active_s2_q;

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  function automatic logic is_rw(input logic [ADDR_W-1:0] a);
    return !((a == A_ZERO) || (a == A_ADC) || (a == A_REST) ||
             (a == A_ACTIVE) || (a == A_FLAG));
  endfunction

  logic wr_rw;
  logic flag_clr;
  logic tick;

  assign wr_rw    = ctrl_writeEnable && is_rw(ctrl_writeReg);
  assign flag_clr = ctrl_writeEnable && (ctrl_writeReg == A_FLAG);
  assign tick     = (div_cnt_q == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic for the divider, the ADC slot and the ready flag
  // ---------------------------------------------------------------------------
  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);
    adc_d     = tick ? adc_in : adc_q;
    pulse_d   = tick;
    // A tick wins over a clear on the same edge so that a sample is never lost.
    if (tick) begin
      flag_d = 1'b1;
    end else if (flag_clr) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      adc_q       <= '0;
      div_cnt_q   <= '0;
      flag_q      <= 1'b0;
      pulse_q     <= 1'b0;
      rest_s1_q   <= 1'b0;
      rest_s2_q   <= 1'b0;
      active_s1_q <= 1'b0;
      active_s2_q <= 1'b0;
    end else begin
      if (wr_rw) begin
        regs_q[ctrl_writeReg] <= data_writeReg;
      end
      adc_q       <= adc_d;
      div_cnt_q   <= div_cnt_d;
      flag_q      <= flag_d;
      pulse_q     <= pulse_d;
      // Two-flop synchronisers. Bit 0 of regs 5/6 follows the input two edges
      // after the input changes.
      rest_s1_q   <= rest_in;
      rest_s2_q   <= rest_s1_q;
      active_s1_q <= active_in;
      active_s2_q <= active_s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. Both ports share one mux description and are fully independent.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = ctrl_readRegA;
  assign rd_addr[1] = ctrl_readRegB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      case (rd_addr[p])
        A_ZERO:   rd_data[p] = '0;
        A_ADC:    rd_data[p] = DATA_W'(adc_q);
        A_REST:   rd_data[p] = DATA_W'(rest_s2_q);
        A_ACTIVE: rd_data[p] = DATA_W'(active_s2_q);
        A_FLAG:   rd_data[p] = DATA_W'(flag_q);
        default:  ;
      endcase
`ifdef WRITE_BYPASS_EN
      // Write-first forwarding. wr_rw already excludes the special slots.
      if (wr_rw && (rd_addr[p] == ctrl_writeReg)) begin
        rd_data[p] = data_writeReg;
      end
`endif
    end
  end

  assign data_readRegA = rd_data[0];
  assign data_readRegB = rd_data[1];

  // ---------------------------------------------------------------------------
  // Exported fields. These are direct slices of flops, so they change on the
  // same edge as the write that loads them.
  // ---------------------------------------------------------------------------
  assign pwm_cfg         = regs_q[A_PWM][PWM_W-1:0];
  assign testing         = regs_q[A_DBG][DBG_LSB +: DBG_W];
  assign adc_ready_pulse = pulse_q;

endmodule

// File: tb/tb_io_mapped_regfile.sv
// -----------------------------------------------------------------------------
// tb_io_mapped_regfile
//
// Directed bench for io_mapped_regfile with its default parameters.
// exp_q holds the edge numbers (counted from reset release) at which
// adc_ready_pulse must be observed high.
// -----------------------------------------------------------------------------
module tb_io_mapped_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int ADC_W  = 8;
  localparam int PWM_W  = 3;
  localparam int DBG_W  = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  always #10 clock = ~clock;

  logic              ctrl_reset_n;
  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;
  logic [ADC_W-1:0]  adc_in;
  logic              rest_in;
  logic              active_in;
  logic [PWM_W-1:0]  pwm_cfg;
  logic              adc_ready_pulse;
  logic [DBG_W-1:0]  testing;

  io_mapped_regfile dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .adc_in           (adc_in),
    .rest_in          (rest_in),
    .active_in        (active_in),
    .pwm_cfg          (pwm_cfg),
    .adc_ready_pulse  (adc_ready_pulse),
    .testing          (testing)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          edge_n  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance one rising edge and settle 1 time unit past it. Each pulse
  // observation is matched against the expected-edge queue.
  task automatic step();
    logic [31:0] exp_edge;
    @(posedge clock);
    #1;
    edge_n++;
    if (adc_ready_pulse === 1'b1) begin
      exp_edge = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check("pulse_edge", 32'(edge_n), exp_edge);
    end else if ((exp_q.size() > 0) && (exp_q[0] == 32'(edge_n))) begin
      exp_edge = exp_q.pop_front();
      check("pulse_missing", {31'd0, adc_ready_pulse}, 32'd1);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = a;
    data_writeReg    = d;
    step();
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    ctrl_readRegA = a;
    #1;
    check(tag, data_readRegA, exp);
  endtask

  task automatic rd_b(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    ctrl_readRegB = a;
    #1;
    check(tag, data_readRegB, exp);
  endtask

  // Assert reset away from the clock edge and check that it acts before any
  // edge. Then hold it for a few edges and release it 1 unit after an edge.
  task automatic do_reset();
    exp_q.delete();
    ctrl_reset_n = 1'b0;
    #1;
    check("rst_pwm_cfg", 32'(pwm_cfg), 32'd0);
    check("rst_testing", 32'(testing), 32'd0);
    check("rst_pulse", {31'd0, adc_ready_pulse}, 32'd0);
    rd_a("rst_r3", 5'd3, 32'd0);
    rd_b("rst_flag", 5'd8, 32'd0);
    rd_a("rst_adc", 5'd1, 32'd0);
    rd_b("rst_rest", 5'd5, 32'd0);
    repeat (3) step();
    ctrl_reset_n = 1'b1;
    edge_n = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    ctrl_reset_n     = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    ctrl_readRegA    = '0;
    ctrl_readRegB    = '0;
    adc_in           = 8'hA5;
    rest_in          = 1'b0;
    active_in        = 1'b0;
    #3;
    do_reset();
    exp_q.push_back(32'd500);
    exp_q.push_back(32'd1000);

    // Edge 1: r0 ignores writes, even while being read in the write cycle.
    ctrl_readRegA = 5'd0;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'hDEADBEEF;
    #1;
    check("r0_during_write", data_readRegA, 32'd0);
    step();
    ctrl_writeEnable = 1'b0;
    rd_a("r0_after_write", 5'd0, 32'd0);

    // Edge 2: the ADC slot is read-only and has not been sampled yet.
    wr(5'd1, 32'hDEADBEEF);
    rd_a("r1_ro_before_tick", 5'd1, 32'd0);

    // Edge 3: r3 write, with read B watching the same address in the write cycle.
    ctrl_readRegB    = 5'd3;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'h12345678;
    #1;
`ifdef WRITE_BYPASS_EN
    check("r3_same_cycle", data_readRegB, 32'h12345678);
`else
    check("r3_same_cycle", data_readRegB, 32'd0);
`endif
    step();
    ctrl_writeEnable = 1'b0;
    rd_b("r3_next_cycle", 5'd3, 32'h12345678);

    // Edges 4-5: exported PWM and debug fields.
    wr(5'd2, 32'h0000_0007);
    check("pwm_cfg", 32'(pwm_cfg), 32'h7);
    wr(5'd12, 32'h0007_FFF8);
    check("testing", 32'(testing), 32'h0000_FFFF);
    rd_a("r2_readback", 5'd2, 32'h7);
    rd_b("r12_readback", 5'd12, 32'h0007_FFF8);

    // Edge 6: r9 = 0x55, read on A in the write cycle.
    ctrl_readRegA    = 5'd9;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd9;
    data_writeReg    = 32'h55;
    #1;
`ifdef WRITE_BYPASS_EN
    check("r9_bypass", data_readRegA, 32'h55);
`else
    check("r9_bypass", data_readRegA, 32'd0);
`endif
    step();
    ctrl_writeEnable = 1'b0;
    rd_a("r9_next_cycle", 5'd9, 32'h55);

    // Edges 7-8: rest_in rises and shows up on reg 5 after exactly two edges.
    rest_in = 1'b1;
    step();
    rd_a("rest_after_1_edge", 5'd5, 32'd0);
    step();
    rd_a("rest_after_2_edges", 5'd5, 32'd1);
    rd_b("active_unaffected", 5'd6, 32'd0);
    rd_a("flag_before_tick", 5'd8, 32'd0);

    // First ADC tick, at edge 500.
    while (edge_n < 499) step();
    rd_a("adc_before_tick", 5'd1, 32'd0);
    step();
    rd_a("adc_at_tick", 5'd1, 32'h0000_00A5);
    rd_b("flag_at_tick", 5'd8, 32'd1);
    step();
    check("pulse_one_cycle", {31'd0, adc_ready_pulse}, 32'd0);
    rd_a("flag_sticky", 5'd8, 32'd1);

    // Edge 502: a clear at a non-tick edge takes effect.
    wr(5'd8, 32'd0);
    rd_a("flag_cleared", 5'd8, 32'd0);
    // Edges 503-504: writes to read-only slots have no effect.
    wr(5'd1, 32'hFFFF_FFFF);
    rd_a("adc_ro", 5'd1, 32'h0000_00A5);
    wr(5'd5, 32'h0);
    rd_a("rest_ro", 5'd5, 32'd1);

    // Edge 1000: a clear coinciding with the tick leaves the flag set. The new
    // sample value is loaded.
    adc_in = 8'h3C;
    while (edge_n < 999) step();
    wr(5'd8, 32'hFFFF_FFFF);
    rd_a("flag_tick_beats_clear", 5'd8, 32'd1);
    rd_b("adc_second_sample", 5'd1, 32'h0000_003C);

    // Mid-divide reset: everything returns to zero and the tick phase restarts.
    while (edge_n < 1200) step();
    do_reset();
    exp_q.push_back(32'd500);
    step();
    step();
    rd_a("rest_resync_after_reset", 5'd5, 32'd1);
    while (edge_n < 499) step();
    rd_a("adc_zero_before_tick", 5'd1, 32'd0);
    step();
    rd_a("adc_after_reset_tick", 5'd1, 32'h0000_003C);
    check("pulse_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
